// File: rtl/model_standard_fnn_output_vector_pkg.sv
// Shared types and sizes for the standard FNN output-vector block.
// Contents: element/control widths, maximum vector lengths, FSM state enum,
// and a helper that clamps a requested length to its hardware maximum.
package model_standard_fnn_pkg;

    localparam int unsigned DATA_SIZE    = 64;
    localparam int unsigned CONTROL_SIZE = 64;
    localparam int unsigned Y            = 64;
    localparam int unsigned L            = 64;
    localparam int unsigned L_IDX_W      = $clog2(L);
    localparam int unsigned PROD_W       = 2 * DATA_SIZE;

    typedef logic signed [DATA_SIZE-1:0] data_t;
    typedef logic [CONTROL_SIZE-1:0]     ctrl_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_H,
        MAC,
        EMIT,
        DONE
    } fnn_output_state_t;

    // Requested length limited to the buffer/counter capacity.
    function automatic ctrl_t clamp_size(input ctrl_t size, input int unsigned lim);
        return (size > ctrl_t'(lim)) ? ctrl_t'(lim) : size;
    endfunction

endpackage

// File: rtl/model_standard_fnn_output_vector_if.sv
// Handshake/data bundle of the FNN output-vector block.
// slave  : the block itself (consumes start/sizes/h/u, produces requests/y/ready).
// master : the controller/producer side driving start, sizes and h/u elements.
interface model_standard_fnn_output_vector_if;
    import model_standard_fnn_pkg::*;

    logic  start;
    logic  ready;
    ctrl_t size_y_in;
    ctrl_t size_l_in;
    logic  h_in_enable;
    data_t h_in;
    logic  h_out_enable;
    logic  u_in_enable;
    data_t u_in;
    logic  u_out_enable;
    logic  y_out_enable;
    data_t y_out;
    logic  overflow;

    modport slave (
        input  start, size_y_in, size_l_in, h_in_enable, h_in, u_in_enable, u_in,
        output ready, h_out_enable, u_out_enable, y_out_enable, y_out, overflow
    );

    modport master (
        output start, size_y_in, size_l_in, h_in_enable, h_in, u_in_enable, u_in,
        input  ready, h_out_enable, u_out_enable, y_out_enable, y_out, overflow
    );

endinterface

// File: rtl/model_standard_fnn_output_vector_mac.sv
// Combinational multiply-accumulate step: sum_c = acc + u*h.
// Ports: acc (running sum), u, h (operands) -> sum_c (new sum), sat_c (saturation hit).
// MODEL_FNN_OUTPUT_SATURATE_EN: product and sum clamp to the signed range and sat_c
// reports any clamp; otherwise low DATA_SIZE bits are kept (modulo arithmetic), sat_c = 0.
module model_standard_fnn_output_mac
    import model_standard_fnn_pkg::*;
(
    input  data_t acc,
    input  data_t u,
    input  data_t h,
    output data_t sum_c,
    output logic  sat_c
);

`ifdef MODEL_FNN_OUTPUT_SATURATE_EN
    localparam data_t DATA_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam data_t DATA_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic signed [PROD_W-1:0] prod_full;
    data_t                    prod;
    data_t                    sum_raw;
    logic                     prod_ovf;
    logic                     add_ovf;

    always_comb begin
        prod_full = PROD_W'(u) * PROD_W'(h);
        // Product fits only if the bits above the result's sign bit are pure sign extension.
        prod_ovf  = (prod_full[PROD_W-1:DATA_SIZE-1] != {(DATA_SIZE+1){prod_full[PROD_W-1]}});
        prod      = prod_ovf ? (prod_full[PROD_W-1] ? DATA_MIN : DATA_MAX)
                             : data_t'(prod_full[DATA_SIZE-1:0]);
        sum_raw   = acc + prod;
        // Signed add overflows when both operands share a sign the result lacks.
        add_ovf   = (acc[DATA_SIZE-1] == prod[DATA_SIZE-1]) &&
                    (sum_raw[DATA_SIZE-1] != acc[DATA_SIZE-1]);
        sum_c     = add_ovf ? (acc[DATA_SIZE-1] ? DATA_MIN : DATA_MAX) : sum_raw;
        sat_c     = prod_ovf | add_ovf;
    end
`else
    data_t prod;

    // Low half of the signed product equals the product taken at DATA_SIZE width.
    always_comb begin
        prod  = u * h;
        sum_c = acc + prod;
        sat_c = 1'b0;
    end
`endif

endmodule

// File: rtl/model_standard_fnn_output_vector.sv
// Output end of the standard FNN controller: y[i] = sum_l U[i][l] * h[l].
// Ports: clk, rst (async, active-low); bus (slave modport) carries start/ready,
// size_y_in/size_l_in, h and U element handshakes (request out, enable+data in),
// y_out/y_out_enable stream and the sticky overflow flag.
// h is buffered once, then U is streamed row by row, one y element per row.
// MODEL_FNN_OUTPUT_SATURATE_EN selects saturating arithmetic with overflow reporting;
// without it arithmetic wraps and overflow stays 0.
module model_standard_fnn_output_vector
    import model_standard_fnn_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    model_standard_fnn_output_vector_if.slave bus
);

    fnn_output_state_t state, state_nxt;

    ctrl_t size_y, size_y_nxt;
    ctrl_t size_l, size_l_nxt;
    ctrl_t l_cnt, l_nxt;
    ctrl_t i_cnt, i_nxt;
    data_t acc, acc_nxt;
    data_t y_out, y_out_nxt;
    data_t hbuf [L];
    logic  hbuf_we;

    logic ready, ready_nxt;
    logic h_req, h_req_nxt;
    logic u_req, u_req_nxt;
    logic y_en, y_en_nxt;
    logic overflow, overflow_nxt;

    ctrl_t              size_y_c, size_l_c;
    logic               h_accept_c, u_accept_c, l_last_c, i_last_c;
    logic [L_IDX_W-1:0] l_idx_c;
    data_t              mac_sum_c;
    logic               mac_sat_c;

    assign size_y_c   = clamp_size(bus.size_y_in, Y);
    assign size_l_c   = clamp_size(bus.size_l_in, L);
    assign h_accept_c = (state == LOAD_H) && bus.h_in_enable;
    assign u_accept_c = (state == MAC) && bus.u_in_enable;
    assign l_last_c   = (l_cnt == size_l - ctrl_t'(1));
    assign i_last_c   = (i_cnt == size_y - ctrl_t'(1));
    assign l_idx_c    = l_cnt[L_IDX_W-1:0];

    model_standard_fnn_output_mac u_mac (
        .acc   (acc),
        .u     (bus.u_in),
        .h     (hbuf[l_idx_c]),
        .sum_c (mac_sum_c),
        .sat_c (mac_sat_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (size_y_c == '0)      state_nxt = DONE;
                    else if (size_l_c == '0) state_nxt = EMIT;
                    else                     state_nxt = LOAD_H;
                end
            end
            LOAD_H:  if (h_accept_c && l_last_c) state_nxt = MAC;
            MAC:     if (u_accept_c && l_last_c) state_nxt = EMIT;
            EMIT: begin
                if (i_last_c)           state_nxt = DONE;
                else if (size_l == '0)  state_nxt = EMIT;
                else                    state_nxt = MAC;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values; y/requests are set up one cycle ahead so
    // they appear registered in the cycle they belong to.
    always_comb begin
        size_y_nxt   = size_y;
        size_l_nxt   = size_l;
        l_nxt        = l_cnt;
        i_nxt        = i_cnt;
        acc_nxt      = acc;
        y_out_nxt    = y_out;
        hbuf_we      = 1'b0;
        ready_nxt    = (state == DONE);
        h_req_nxt    = 1'b0;
        u_req_nxt    = 1'b0;
        y_en_nxt     = 1'b0;
        overflow_nxt = overflow;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    size_y_nxt   = size_y_c;
                    size_l_nxt   = size_l_c;
                    l_nxt        = '0;
                    i_nxt        = '0;
                    acc_nxt      = '0;
                    overflow_nxt = 1'b0;
                    if (state_nxt == LOAD_H) h_req_nxt = 1'b1;
                    if (state_nxt == EMIT) begin
                        y_en_nxt  = 1'b1;
                        y_out_nxt = '0;
                    end
                end
            end
            LOAD_H: begin
                if (h_accept_c) begin
                    hbuf_we = 1'b1;
                    if (l_last_c) begin
                        l_nxt     = '0;
                        u_req_nxt = 1'b1;
                    end else begin
                        l_nxt     = l_cnt + ctrl_t'(1);
                        h_req_nxt = 1'b1;
                    end
                end
            end
            MAC: begin
                if (u_accept_c) begin
                    acc_nxt      = mac_sum_c;
                    overflow_nxt = overflow | mac_sat_c;
                    if (l_last_c) begin
                        y_en_nxt  = 1'b1;
                        y_out_nxt = mac_sum_c;
                    end else begin
                        l_nxt     = l_cnt + ctrl_t'(1);
                        u_req_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                acc_nxt = '0;
                l_nxt   = '0;
                if (!i_last_c) begin
                    i_nxt = i_cnt + ctrl_t'(1);
                    // Zero-length rows emit back to back without any U traffic.
                    if (size_l == '0) begin
                        y_en_nxt  = 1'b1;
                        y_out_nxt = '0;
                    end else begin
                        u_req_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_y   <= '0;
            size_l   <= '0;
            l_cnt    <= '0;
            i_cnt    <= '0;
            acc      <= '0;
            y_out    <= '0;
            ready    <= 1'b0;
            h_req    <= 1'b0;
            u_req    <= 1'b0;
            y_en     <= 1'b0;
            overflow <= 1'b0;
            for (int k = 0; k < int'(L); k++) hbuf[k] <= '0;
        end else begin
            size_y   <= size_y_nxt;
            size_l   <= size_l_nxt;
            l_cnt    <= l_nxt;
            i_cnt    <= i_nxt;
            acc      <= acc_nxt;
            y_out    <= y_out_nxt;
            ready    <= ready_nxt;
            h_req    <= h_req_nxt;
            u_req    <= u_req_nxt;
            y_en     <= y_en_nxt;
            overflow <= overflow_nxt;
            if (hbuf_we) hbuf[l_idx_c] <= bus.h_in;
        end
    end

    assign bus.ready        = ready;
    assign bus.h_out_enable = h_req;
    assign bus.u_out_enable = u_req;
    assign bus.y_out_enable = y_en;
    assign bus.y_out        = y_out;
    assign bus.overflow     = overflow;

endmodule
